muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Iterative RV32M multiply/divide sequencer in the EX stage, beside the single-cycle ALU. It accepts one M-extension operation at a time from the EX issue logic over a valid/ready handshake. It runs a 32-step shift-add multiply or a restoring divide, then holds the result until the writeback path takes it. While it works it raises `busy`, which the hazard unit uses to stall the pipeline.

## Interface
- `DATA_WIDTH`, default 32: operand and result width. Only 32 is supported.
- `clk` input 1: core clock.
- `rst_n` input 1: reset, synchronous, active-low. The design has one clock.
- `req_valid` input 1: EX presents an M-extension operation.
- `req_ready` output 1: the unit can accept a request (state IDLE).
- `req_op` input 3: funct3 of the instruction. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `req_rs1` input DATA_WIDTH: operand a.
- `req_rs2` input DATA_WIDTH: operand b.
- `flush` input 1: pipeline flush. Aborts any operation in flight.
- `resp_valid` output 1: `resp_data` is valid.
- `resp_ready` input 1: writeback consumes the result.
- `resp_data` output DATA_WIDTH: the result.
- `busy` output 1: state is not IDLE. Used as the stall request.

## Operation
- **States:** IDLE, MUL, DIV, DONE.
- **Reset values:** state IDLE, counter 0, all datapath registers 0.
  - Outputs: `req_ready`=1, `resp_valid`=0, `resp_data`=0, `busy`=0.
- **IDLE:**
  - A request is accepted when `req_valid & req_ready & ~flush`.
  - On accept, latch the op, both operand magnitudes and the result sign, then clear the counter.
  - For signed operands (MULH/MULHSU rs1; MULH/DIV/REM rs1 and rs2), take the magnitude as the two's complement when the MSB is 1.
- **Accepted op goes to:**
  - MUL for ops 000–011.
  - DIV for ops 100–111 with rs2 ≠ 0 and no overflow.
  - DONE directly for the special cases below.
- **MUL:**
  - One shift-add step per cycle on a 64-bit product register. The counter runs 0..31.
  - At counter 31 go to DONE and apply the final fix-ups:
    - negate the 64-bit product if the result is negative;
    - MUL selects the low word; the other multiply ops select the high word.
- **DIV:**
  - One restoring step per cycle, computed in sub-module `muldiv_divstep`. The counter runs 0..31.
  - At counter 31 go to DONE and apply the final fix-ups:
    - the quotient is negated when the operand signs differ (DIV);
    - the remainder takes the sign of the dividend (REM).
- **Special cases (resolved in the accept cycle, no iteration):**
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- **DONE:**
  - `resp_valid`=1 and `resp_data` is stable.
  - `resp_ready`=1 returns the unit to IDLE next cycle and clears `resp_valid`.
  - With `resp_ready`=0 the result is held indefinitely.
  - No new request is accepted in the same cycle the response is consumed.
- **Flush:**
  - In any state, `flush`=1 forces IDLE at the next edge, clears `resp_valid` and discards the operation.
  - Flush wins over a simultaneous `req_valid` or `resp_ready`.
- **Reset mid-operation:** `rst_n`=0 at any edge restores all reset values. No response is produced.
- **Width rules:**
  - Internal product is 64 bits.
  - Divider remainder path is 33 bits: 32-bit remainder plus the subtraction borrow.
  - Counter is 5 bits and never wraps past 31.

## Timing
- Accept at edge T (request sampled in cycle T):
  - iterative ops: first step at T+1, last step at T+32, `resp_valid` high from T+33;
  - special cases: `resp_valid` high from T+1.
- `req_ready` and `busy` are combinational from state only. There is no combinational path from `req_valid` to `req_ready`.
- `resp_data` is registered.
- Back-to-back throughput: accept, then 33 cycles to response, then at least one cycle to consume. The next accept is possible in the first IDLE cycle after consumption.

## Structure
- Shared include gets:
  - the funct3 op encodings (`MULDIV_OP_*`);
  - the state encoding constants;
  - `MULDIV_ITER` = 32.
- `muldiv_divstep` is a combinational sub-module.
  - Inputs: partial remainder and quotient register, divisor.
  - Outputs: next remainder and quotient (shift, trial subtract, restore on borrow).
- The multiply step is inline in `muldiv_ctrl`.

## Test plan
- MUL 7 × 0xFFFFFFFD → `resp_data` 0xFFFFFFEB, with `resp_valid` rising exactly 33 cycles after accept. Also check `req_ready`=0 and `busy`=1 throughout.
- Same operands 0xFFFFFFFF × 0xFFFFFFFF across the high-word ops:
  - MULHU → 0xFFFFFFFE;
  - MULH → 0x00000000;
  - MULHSU → 0xFFFFFFFF.
- rs1=0xFFFFFFF9 (−7), rs2=2:
  - DIV → 0xFFFFFFFD;
  - REM → 0xFFFFFFFF;
  - DIVU 100/7 → 14;
  - REMU 100/7 → 2.
- Special cases, all returning one cycle after accept:
  - DIVU 5/0 → 0xFFFFFFFF;
  - REM 5/0 → 5;
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000;
  - REM of the same → 0.
- Backpressure: hold `resp_ready`=0 for 10 cycles in DONE → `resp_data` is stable and `resp_valid` stays 1. On release, IDLE follows the next cycle.
- Flush and reset:
  - `flush` at step 10 → `resp_valid` is never asserted and `req_ready`=1 next cycle.
  - `flush` together with `req_valid` in IDLE → request not accepted.
  - `rst_n`=0 mid-DIV → all outputs at reset values next cycle.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide sequencer:
// funct3 encodings, FSM state type, iteration count and op-decode helpers.
package muldiv_ctrl_pkg;

    localparam int MULDIV_ITER = 32;

    localparam logic [2:0] MULDIV_OP_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_OP_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_OP_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_OP_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_OP_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_OP_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_OP_REM    = 3'b110;
    localparam logic [2:0] MULDIV_OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return op == MULDIV_OP_REM || op == MULDIV_OP_REMU;
    endfunction

    function automatic logic op_rs1_signed(input logic [2:0] op);
        return op == MULDIV_OP_MULH || op == MULDIV_OP_MULHSU ||
               op == MULDIV_OP_DIV  || op == MULDIV_OP_REM;
    endfunction

    function automatic logic op_rs2_signed(input logic [2:0] op);
        return op == MULDIV_OP_MULH || op == MULDIV_OP_DIV || op == MULDIV_OP_REM;
    endfunction

    // Only MUL returns the low product word; MULH/MULHSU/MULHU return the high word.
    function automatic logic op_low_word(input logic [2:0] op);
        return op == MULDIV_OP_MUL;
    endfunction

    function automatic logic op_signed_div(input logic [2:0] op);
        return op == MULDIV_OP_DIV || op == MULDIV_OP_REM;
    endfunction

    function automatic logic op_unused_check(input logic [2:0] op);
        return op == MULDIV_OP_MULHU || op == MULDIV_OP_DIVU || op == MULDIV_OP_REMU;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/response handshake bundle between EX issue, the M-unit and writeback,
// plus the flush input and busy stall output.
interface muldiv_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            req_op;
    logic [DATA_WIDTH-1:0] req_rs1;
    logic [DATA_WIDTH-1:0] req_rs2;
    logic                  flush;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  busy;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, flush, resp_ready,
        input  req_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, flush, resp_ready,
        output req_ready, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/muldiv_divstep.sv
// One restoring-division step: shift the remainder/quotient pair left by one,
// trial-subtract the divisor and restore on borrow.
module muldiv_divstep #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem,
    input  logic [DATA_WIDTH-1:0] quot,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_next,
    output logic [DATA_WIDTH-1:0] quot_next
);
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH-1:0] diff;
    logic                  borrow;

    assign shifted = {rem, quot[DATA_WIDTH-1]};

    // rem < divisor always holds, so a set carry-out bit guarantees no borrow and
    // the true difference fits in DATA_WIDTH bits.
    assign borrow    = ~shifted[DATA_WIDTH] & (shifted[DATA_WIDTH-1:0] < divisor);
    assign diff      = shifted[DATA_WIDTH-1:0] - divisor;
    assign rem_next  = borrow ? shifted[DATA_WIDTH-1:0] : diff;
    assign quot_next = {quot[DATA_WIDTH-2:0], ~borrow};
endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative RV32M sequencer: 32-step shift-add multiply or restoring divide on
// operand magnitudes, with sign fix-up on the final step and a held result.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_ctrl_if.slave  bus
);
    localparam int W = DATA_WIDTH;
    localparam logic [4:0] LAST_STEP = 5'(MULDIV_ITER - 1);

    state_t         state_reg, state_next;
    logic [4:0]     cnt_reg, cnt_next;
    logic [2:0]     op_reg, op_next;
    logic           neg_reg, neg_next;
    logic [W-1:0]   opnd_reg, opnd_next;
    logic [2*W-1:0] prod_reg, prod_next;
    logic [W-1:0]   resp_data_reg, resp_data_next;

    // Accept-cycle decode
    logic         accept;
    logic         rs1_neg, rs2_neg;
    logic [W-1:0] rs1_mag, rs2_mag;
    logic         div_by_zero, div_ovf;

    assign accept      = bus.req_valid & (state_reg == IDLE) & ~bus.flush;
    assign rs1_neg     = op_rs1_signed(bus.req_op) & bus.req_rs1[W-1];
    assign rs2_neg     = op_rs2_signed(bus.req_op) & bus.req_rs2[W-1];
    assign rs1_mag     = rs1_neg ? -bus.req_rs1 : bus.req_rs1;
    assign rs2_mag     = rs2_neg ? -bus.req_rs2 : bus.req_rs2;
    assign div_by_zero = (bus.req_rs2 == '0);
    assign div_ovf     = op_signed_div(bus.req_op) &&
                         (bus.req_rs1 == {1'b1, {(W-1){1'b0}}}) &&
                         (bus.req_rs2 == '1);

    // Multiply step: upper half accumulates the multiplicand, LSB of the lower half
    // is the current multiplier bit, and the whole register shifts right.
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_step, mul_signed;
    logic [W-1:0]   mul_result;

    assign mul_sum    = {1'b0, prod_reg[2*W-1:W]} + (prod_reg[0] ? {1'b0, opnd_reg} : '0);
    assign mul_step   = {mul_sum, prod_reg[W-1:1]};
    assign mul_signed = neg_reg ? -mul_step : mul_step;
    assign mul_result = op_low_word(op_reg) ? mul_signed[W-1:0] : mul_signed[2*W-1:W];

    // Divide step: upper half holds the partial remainder, lower half the
    // dividend shifting out as quotient bits shift in.
    logic [W-1:0] div_rem, div_quot, div_result;

    muldiv_divstep #(
        .DATA_WIDTH (W)
    ) u_divstep (
        .rem       (prod_reg[2*W-1:W]),
        .quot      (prod_reg[W-1:0]),
        .divisor   (opnd_reg),
        .rem_next  (div_rem),
        .quot_next (div_quot)
    );

    assign div_result = op_is_rem(op_reg) ? (neg_reg ? -div_rem  : div_rem)
                                          : (neg_reg ? -div_quot : div_quot);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        op_next        = op_reg;
        neg_next       = neg_reg;
        opnd_next      = opnd_reg;
        prod_next      = prod_reg;
        resp_data_next = resp_data_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    op_next  = bus.req_op;
                    cnt_next = '0;
                    if (!op_is_div(bus.req_op)) begin
                        neg_next   = rs1_neg ^ rs2_neg;
                        opnd_next  = rs1_mag;
                        prod_next  = {{W{1'b0}}, rs2_mag};
                        state_next = MUL;
                    end else begin
                        // Remainder follows the dividend; quotient follows the sign product.
                        neg_next  = op_is_rem(bus.req_op) ? rs1_neg : (rs1_neg ^ rs2_neg);
                        opnd_next = rs2_mag;
                        prod_next = {{W{1'b0}}, rs1_mag};
                        if (div_by_zero) begin
                            resp_data_next = op_is_rem(bus.req_op) ? bus.req_rs1 : '1;
                            state_next     = DONE;
                        end else if (div_ovf) begin
                            resp_data_next = op_is_rem(bus.req_op) ? '0 : bus.req_rs1;
                            state_next     = DONE;
                        end else begin
                            state_next = DIV;
                        end
                    end
                end
            end
            MUL: begin
                prod_next = mul_step;
                if (cnt_reg == LAST_STEP) begin
                    resp_data_next = mul_result;
                    state_next     = DONE;
                end else begin
                    cnt_next = cnt_reg + 5'd1;
                end
            end
            DIV: begin
                prod_next = {div_rem, div_quot};
                if (cnt_reg == LAST_STEP) begin
                    resp_data_next = div_result;
                    state_next     = DONE;
                end else begin
                    cnt_next = cnt_reg + 5'd1;
                end
            end
            DONE: begin
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Flush discards everything in flight, including a result that would land now.
        if (bus.flush) begin
            state_next     = IDLE;
            resp_data_next = resp_data_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            op_reg        <= '0;
            neg_reg       <= 1'b0;
            opnd_reg      <= '0;
            prod_reg      <= '0;
            resp_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            op_reg        <= op_next;
            neg_reg       <= neg_next;
            opnd_reg      <= opnd_next;
            prod_reg      <= prod_next;
            resp_data_reg <= resp_data_next;
        end
    end

    assign bus.req_ready  = (state_reg == IDLE);
    assign bus.busy       = (state_reg != IDLE);
    assign bus.resp_valid = (state_reg == DONE);
    assign bus.resp_data  = resp_data_reg;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed table-driven bench for muldiv_ctrl plus hand-written sequences for
// backpressure, flush and mid-operation reset.
module tb_muldiv_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    muldiv_ctrl_if #(.DATA_WIDTH(32)) bus ();

    muldiv_ctrl #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Presents one request and waits for the response; returns the edge count
    // from presentation (accept edge = 1) to resp_valid, or -1 on timeout.
    task automatic issue(input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                         output int lat, output logic stall_bad);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
        lat       = 0;
        stall_bad = 1'b0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) bus.req_valid = 1'b0;
            if (!bus.resp_valid && (bus.busy !== 1'b1 || bus.req_ready !== 1'b0))
                stall_bad = 1'b1;
        end while (!bus.resp_valid && lat < 100);
        if (!bus.resp_valid) lat = -1;
    endtask

    task automatic consume();
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check("consume_valid_low", {31'b0, bus.resp_valid}, 32'd0);
        check("consume_ready_high", {31'b0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        int         lat;
        logic       stall_bad;
        logic [31:0] held;
        logic       seen;

        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33};
        vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
        vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       33};
        vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
        vecs[8]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,        1};
        vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        vecs[12] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33};
        vecs[13] = '{3'b001, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 33};
        vecs[14] = '{3'b100, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33};
        vecs[15] = '{3'b110, 32'd20,       32'hFFFFFFFD, 32'd2,        33};
        vecs[16] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};
        vecs[17] = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
        vecs[18] = '{3'b011, 32'h80000000, 32'h00000004, 32'h00000002, 33};
        vecs[19] = '{3'b100, 32'd0,        32'd0,        32'hFFFFFFFF, 1};

        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = 3'b000;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.flush      = 1'b0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready",  {31'b0, bus.req_ready},  32'd1);
        check("reset_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("reset_resp_data",  bus.resp_data,           32'd0);
        check("reset_busy",       {31'b0, bus.busy},       32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].op, vecs[i].rs1, vecs[i].rs2, lat, stall_bad);
            $display("vec %0d op=%0d rs1=%h rs2=%h data=%h lat=%0d", i, vecs[i].op,
                     vecs[i].rs1, vecs[i].rs2, bus.resp_data, lat);
            check($sformatf("vec%0d_data", i), bus.resp_data, vecs[i].exp_data);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_stall", i), {31'b0, stall_bad}, 32'd0);
            consume();
        end

        // Backpressure: result held for 10 cycles with resp_ready low.
        issue(3'b000, 32'd1234, 32'd1000, lat, stall_bad);
        held = bus.resp_data;
        check("bp_data", held, 32'd1234000);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", {31'b0, bus.resp_valid}, 32'd1);
            check("bp_hold_data", bus.resp_data, 32'd1234000);
        end
        $display("backpressure data=%h held 10 cycles", bus.resp_data);
        consume();

        // Flush mid-divide: no response may ever appear.
        bus.req_valid = 1'b1;
        bus.req_op    = 3'b101;
        bus.req_rs1   = 32'd100;
        bus.req_rs2   = 32'd7;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("flush_pre_busy", {31'b0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("flush_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid) seen = 1'b1;
        end
        check("flush_no_resp", {31'b0, seen}, 32'd0);
        $display("flush mid-divide resp_valid_seen=%0d", seen);

        // Flush together with a request in IDLE: request must be dropped.
        bus.req_valid = 1'b1;
        bus.req_op    = 3'b110;
        bus.req_rs1   = 32'd5;
        bus.req_rs2   = 32'd0;
        bus.flush     = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        check("flush_req_busy", {31'b0, bus.busy}, 32'd0);
        check("flush_req_ready2", {31'b0, bus.req_ready}, 32'd1);
        check("flush_req_no_resp", {31'b0, bus.resp_valid}, 32'd0);
        $display("flush with request busy=%0d resp_valid=%0d", bus.busy, bus.resp_valid);

        // Unit still usable after flushes.
        issue(3'b111, 32'd100, 32'd7, lat, stall_bad);
        $display("post-flush REMU data=%h lat=%0d", bus.resp_data, lat);
        check("postflush_data", bus.resp_data, 32'd2);
        check("postflush_latency", lat, 33);
        consume();

        // Reset mid-divide: everything back to reset values.
        bus.req_valid = 1'b1;
        bus.req_op    = 3'b100;
        bus.req_rs1   = 32'd1000;
        bus.req_rs2   = 32'd3;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_mid_req_ready",  {31'b0, bus.req_ready},  32'd1);
        check("rst_mid_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("rst_mid_resp_data",  bus.resp_data,           32'd0);
        check("rst_mid_busy",       {31'b0, bus.busy},       32'd0);
        $display("reset mid-divide ready=%0d valid=%0d data=%h busy=%0d",
                 bus.req_ready, bus.resp_valid, bus.resp_data, bus.busy);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid) seen = 1'b1;
        end
        check("rst_no_resp", {31'b0, seen}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
